// File: rtl/r2_w1_mem_arbiter_if.sv
// Bundle between NUM_REQ requesters, the arbiter and a 2-read/1-write memory.
// Slave is the arbiter view; master is the environment (requesters plus memory).
interface r2_w1_mem_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // A request transfers in the cycle req_valid & req_ready are both high. req_ready is a
    // same-cycle grant and never a precondition for asserting req_valid. rsp_valid is a
    // single-cycle pulse exactly one clock after the transfer.
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0]                 req_we;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]                 rsp_valid;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rsp_data;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_w_addr;
    logic [DATA_WIDTH-1:0] mem_w_data;
    logic [ADDR_WIDTH-1:0] mem_r0_addr;
    logic [DATA_WIDTH-1:0] mem_r0_data;
    logic [ADDR_WIDTH-1:0] mem_r1_addr;
    logic [DATA_WIDTH-1:0] mem_r1_data;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_r0_data, mem_r1_data,
        output req_ready, rsp_valid, rsp_data,
        output mem_we, mem_w_addr, mem_w_data, mem_r0_addr, mem_r1_addr
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_r0_data, mem_r1_data,
        input  req_ready, rsp_valid, rsp_data,
        input  mem_we, mem_w_addr, mem_w_data, mem_r0_addr, mem_r1_addr
    );
endinterface

// File: rtl/r2_w1_mem_arbiter.sv
// Round-robin arbiter granting up to two reads and one write per cycle onto a shared
// 2R/1W memory, returning registered responses one cycle after each grant.
module r2_w1_mem_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    r2_w1_mem_arbiter_if.slave   bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NUM_REQ-1:0]                 rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic          wr_hit, rd0_hit, rd1_hit;
    logic [PW-1:0] wr_idx, rd0_idx, rd1_idx;
    logic [NUM_REQ-1:0] grant_w, grant_r0, grant_r1;

    // Index k steps past base, wrapping at NUM_REQ (which need not be a power of two).
    function automatic logic [PW-1:0] rot(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PW'(s);
    endfunction

    always_comb begin
        wr_hit  = 1'b0;
        wr_idx  = '0;
        rd0_hit = 1'b0;
        rd0_idx = '0;
        rd1_hit = 1'b0;
        rd1_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!wr_hit && bus.req_valid[rot(wr_ptr_q, k)] && bus.req_we[rot(wr_ptr_q, k)]) begin
                wr_hit = 1'b1;
                wr_idx = rot(wr_ptr_q, k);
            end
            if (bus.req_valid[rot(rd_ptr_q, k)] && !bus.req_we[rot(rd_ptr_q, k)]) begin
                if (!rd0_hit) begin
                    rd0_hit = 1'b1;
                    rd0_idx = rot(rd_ptr_q, k);
                end else if (!rd1_hit) begin
                    rd1_hit = 1'b1;
                    rd1_idx = rot(rd_ptr_q, k);
                end
            end
        end
    end

    // Grants and memory drive are suppressed while in reset so nothing leaks to the memory.
    always_comb begin
        grant_w         = '0;
        grant_r0        = '0;
        grant_r1        = '0;
        bus.mem_we      = 1'b0;
        bus.mem_w_addr  = '0;
        bus.mem_w_data  = '0;
        bus.mem_r0_addr = '0;
        bus.mem_r1_addr = '0;
        if (rst_ni) begin
            if (wr_hit) begin
                grant_w[wr_idx] = 1'b1;
                bus.mem_we      = 1'b1;
                bus.mem_w_addr  = bus.req_addr[wr_idx];
                bus.mem_w_data  = bus.req_wdata[wr_idx];
            end
            if (rd0_hit) begin
                grant_r0[rd0_idx] = 1'b1;
                bus.mem_r0_addr   = bus.req_addr[rd0_idx];
            end
            if (rd1_hit) begin
                grant_r1[rd1_idx] = 1'b1;
                bus.mem_r1_addr   = bus.req_addr[rd1_idx];
            end
        end
        bus.req_ready = grant_w | grant_r0 | grant_r1;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_hit) wr_ptr_d = rot(wr_idx, 1);
        if (rd1_hit)      rd_ptr_d = rot(rd1_idx, 1);
        else if (rd0_hit) rd_ptr_d = rot(rd0_idx, 1);
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid_d[i] = grant_w[i] | grant_r0[i] | grant_r1[i];
            if (grant_r0[i])      rsp_data_d[i] = bus.mem_r0_data;
            else if (grant_r1[i]) rsp_data_d[i] = bus.mem_r1_data;
            else if (grant_w[i])  rsp_data_d[i] = '0;
            else                  rsp_data_d[i] = rsp_data_q[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_r2_w1_mem_arbiter.sv
// Self-checking bench for r2_w1_mem_arbiter: directed scenarios plus a randomized run
// against a rotation-distance reference model and a response scoreboard.
module tb_r2_w1_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    r2_w1_mem_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    r2_w1_mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    // Memory model: combinational reads, write lands on the clock edge.
    logic [DW-1:0] mem_arr [0:4095];
    assign bus.mem_r0_data = mem_arr[bus.mem_r0_addr[11:0]];
    assign bus.mem_r1_data = mem_arr[bus.mem_r1_addr[11:0]];
    always @(posedge clk) if (bus.mem_we) mem_arr[bus.mem_w_addr[11:0]] <= bus.mem_w_data;

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        bus.req_valid[i] = 1'b1;
        bus.req_we[i]    = we;
        bus.req_addr[i]  = a;
        bus.req_wdata[i] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = '1;
        bus.req_we    = 4'b1010;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i]  = AW'(32'h40 + 4 * i);
            bus.req_wdata[i] = DW'(32'h1000 + i);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.req_ready !== 4'b0000)
                $display("FAIL reset_ready c%0d: got %b want 0000", c, bus.req_ready);
            else n_pass++;
            n_checks++;
            if (bus.mem_we !== 1'b0) $display("FAIL reset_mem_we c%0d: got %b want 0", c, bus.mem_we);
            else n_pass++;
            n_checks++;
            if (bus.rsp_valid !== 4'b0000)
                $display("FAIL reset_rsp_valid c%0d: got %b want 0000", c, bus.rsp_valid);
            else n_pass++;
            n_checks++;
            if ((bus.mem_w_addr | bus.mem_w_data | bus.mem_r0_addr | bus.mem_r1_addr) !== '0)
                $display("FAIL reset_mem_bus c%0d: got w %h/%h r0 %h r1 %h want all 0", c,
                         bus.mem_w_addr, bus.mem_w_data, bus.mem_r0_addr, bus.mem_r1_addr);
            else n_pass++;
            tick();
        end
        idle_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        set_req(2, 1'b0, 32'h4, 32'h0);
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 4'b0100) $display("FAIL mid_ready: got %b want 0100", bus.req_ready);
        else n_pass++;
        rst_n = 1'b0;
        tick();
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 4'b0000) $display("FAIL mid_drop: got %b want 0000", bus.rsp_valid);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 4'b0000) $display("FAIL mid_no_late: got %b want 0000", bus.rsp_valid);
        else n_pass++;
        tick();
    endtask

    task automatic test_single_read();
        do_reset();
        set_req(0, 1'b1, 32'h400, 32'hCAFE0001);
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 4'b0001 || bus.mem_we !== 1'b1 || bus.mem_w_addr !== 32'h400)
            $display("FAIL sr_preload: got rdy %b we %b addr %h want 0001 1 400",
                     bus.req_ready, bus.mem_we, bus.mem_w_addr);
        else n_pass++;
        tick();
        idle_inputs();
        set_req(1, 1'b0, 32'h400, 32'h0);
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 4'b0010 || bus.mem_r0_addr !== 32'h400)
            $display("FAIL sr_grant: got rdy %b r0 %h want 0010 400", bus.req_ready, bus.mem_r0_addr);
        else n_pass++;
        n_checks++;
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_data[0] !== 32'h0)
            $display("FAIL sr_write_ack: got v %b d %h want 0001 0", bus.rsp_valid, bus.rsp_data[0]);
        else n_pass++;
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_data[1] !== 32'hCAFE0001)
            $display("FAIL sr_rsp: got v %b d %h want 0010 cafe0001", bus.rsp_valid, bus.rsp_data[1]);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 4'b0000 || bus.rsp_data[1] !== 32'hCAFE0001)
            $display("FAIL sr_one_pulse: got v %b d %h want 0000 cafe0001", bus.rsp_valid, bus.rsp_data[1]);
        else n_pass++;
        tick();
    endtask

    task automatic test_dual_read_write();
        do_reset();
        set_req(0, 1'b0, 32'h4,  32'h0);
        set_req(1, 1'b0, 32'h8,  32'h0);
        set_req(2, 1'b1, 32'hC,  32'hAAAA0002);
        set_req(3, 1'b1, 32'h10, 32'hAAAA0003);
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 4'b0111) $display("FAIL dual_ready0: got %b want 0111", bus.req_ready);
        else n_pass++;
        n_checks++;
        if (bus.mem_r0_addr !== 32'h4 || bus.mem_r1_addr !== 32'h8)
            $display("FAIL dual_raddr: got r0 %h r1 %h want 4 8", bus.mem_r0_addr, bus.mem_r1_addr);
        else n_pass++;
        n_checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_w_addr !== 32'hC || bus.mem_w_data !== 32'hAAAA0002)
            $display("FAIL dual_write0: got %b %h %h want 1 c aaaa0002",
                     bus.mem_we, bus.mem_w_addr, bus.mem_w_data);
        else n_pass++;
        tick();
        bus.req_valid[2:0] = 3'b000;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 4'b1000 || bus.mem_w_addr !== 32'h10 || bus.mem_w_data !== 32'hAAAA0003)
            $display("FAIL dual_write1: got rdy %b addr %h data %h want 1000 10 aaaa0003",
                     bus.req_ready, bus.mem_w_addr, bus.mem_w_data);
        else n_pass++;
        n_checks++;
        if (bus.rsp_valid !== 4'b0111 || bus.rsp_data[2] !== 32'h0)
            $display("FAIL dual_rsp0: got v %b d2 %h want 0111 0", bus.rsp_valid, bus.rsp_data[2]);
        else n_pass++;
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 4'b1000 || bus.rsp_data[3] !== 32'h0)
            $display("FAIL dual_rsp1: got v %b d3 %h want 1000 0", bus.rsp_valid, bus.rsp_data[3]);
        else n_pass++;
        tick();
    endtask

    // Runs straight after test_dual_read_write, where the write pointer has wrapped to 0.
    task automatic test_round_robin();
        int acks[N];
        logic [N-1:0] want;
        for (int i = 0; i < N; i++) begin
            acks[i] = 0;
            set_req(i, 1'b1, AW'(32'h20 + 4 * i), DW'(32'hB0 + i));
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            want = N'(1) << (c % N);
            n_checks++;
            if (bus.req_ready !== want || bus.mem_w_addr !== AW'(32'h20 + 4 * (c % N)))
                $display("FAIL rr_order c%0d: got rdy %b addr %h want %b %h", c, bus.req_ready,
                         bus.mem_w_addr, want, 32'h20 + 4 * (c % N));
            else n_pass++;
            for (int i = 0; i < N; i++) if (bus.rsp_valid[i] === 1'b1) acks[i]++;
            tick();
        end
        idle_inputs();
        @(negedge clk);
        for (int i = 0; i < N; i++) if (bus.rsp_valid[i] === 1'b1) acks[i]++;
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (acks[i] != 2) $display("FAIL rr_acks req%0d: got %0d want 2", i, acks[i]);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_raw_same_cycle();
        set_req(0, 1'b1, 32'h200, 32'h11);
        tick();
        idle_inputs();
        set_req(0, 1'b1, 32'h200, 32'h55);
        set_req(1, 1'b0, 32'h200, 32'h0);
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 4'b0011) $display("FAIL raw_ready: got %b want 0011", bus.req_ready);
        else n_pass++;
        tick();
        idle_inputs();
        set_req(1, 1'b0, 32'h200, 32'h0);
        @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 4'b0011 || bus.rsp_data[1] !== 32'h11)
            $display("FAIL raw_old: got v %b d %h want 0011 11", bus.rsp_valid, bus.rsp_data[1]);
        else n_pass++;
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_data[1] !== 32'h55)
            $display("FAIL raw_new: got v %b d %h want 0010 55", bus.rsp_valid, bus.rsp_data[1]);
        else n_pass++;
        tick();
    endtask

    // Reference model: among candidates, the winner is the one at the smallest rotational
    // distance from the pointer; the pointer then moves just past the last winner.
    task automatic test_random();
        logic [DW-1:0] model_mem [16];
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] exp_d;
        logic [N-1:0]  pv, pwe, exp_ready, exp_rsp_v;
        logic [AW-1:0] pa [N];
        logic [DW-1:0] pd [N];
        int            waitc [N];
        int            wq[$], rq[$];
        int            m_wr, m_rd, w_win, r0, r1, bound;
        logic [AW-1:0] exp_wa, exp_r0a, exp_r1a;
        logic [DW-1:0] exp_wd;

        for (int a = 0; a < 16; a++) begin
            model_mem[a] = $urandom;
            idle_inputs();
            set_req(0, 1'b1, AW'(a), model_mem[a]);
            tick();
        end
        do_reset();
        m_wr = 0;
        m_rd = 0;
        pv = '0;
        pwe = '0;
        exp_rsp_v = '0;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            pa[i] = '0;
            pd[i] = '0;
            waitc[i] = 0;
        end

        for (int cyc = 0; cyc < 5000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(0, 99) < 60) begin
                    pv[i]    = 1'b1;
                    pwe[i]   = ($urandom_range(0, 2) == 0);
                    pa[i]    = AW'($urandom_range(0, 15));
                    pd[i]    = $urandom;
                    waitc[i] = 0;
                end
                bus.req_valid[i] = pv[i];
                bus.req_we[i]    = pwe[i];
                bus.req_addr[i]  = pa[i];
                bus.req_wdata[i] = pd[i];
            end

            wq.delete();
            rq.delete();
            for (int i = 0; i < N; i++) begin
                if (pv[i] && pwe[i])  wq.push_back((i - m_wr + N) % N);
                if (pv[i] && !pwe[i]) rq.push_back((i - m_rd + N) % N);
            end
            wq.sort();
            rq.sort();
            w_win = (wq.size() > 0) ? (wq[0] + m_wr) % N : -1;
            r0    = (rq.size() > 0) ? (rq[0] + m_rd) % N : -1;
            r1    = (rq.size() > 1) ? (rq[1] + m_rd) % N : -1;
            exp_ready = '0;
            exp_wa = '0; exp_wd = '0; exp_r0a = '0; exp_r1a = '0;
            if (w_win >= 0) begin exp_ready[w_win] = 1'b1; exp_wa = pa[w_win]; exp_wd = pd[w_win]; end
            if (r0 >= 0) begin exp_ready[r0] = 1'b1; exp_r0a = pa[r0]; end
            if (r1 >= 0) begin exp_ready[r1] = 1'b1; exp_r1a = pa[r1]; end

            @(negedge clk);
            n_checks++;
            if (bus.req_ready !== exp_ready)
                $display("FAIL rnd_ready cyc%0d: got %b want %b", cyc, bus.req_ready, exp_ready);
            else n_pass++;
            n_checks++;
            if (bus.mem_we !== (w_win >= 0) || bus.mem_w_addr !== exp_wa || bus.mem_w_data !== exp_wd)
                $display("FAIL rnd_write cyc%0d: got %b %h %h want %b %h %h", cyc, bus.mem_we,
                         bus.mem_w_addr, bus.mem_w_data, (w_win >= 0), exp_wa, exp_wd);
            else n_pass++;
            n_checks++;
            if (bus.mem_r0_addr !== exp_r0a || bus.mem_r1_addr !== exp_r1a)
                $display("FAIL rnd_raddr cyc%0d: got %h %h want %h %h", cyc,
                         bus.mem_r0_addr, bus.mem_r1_addr, exp_r0a, exp_r1a);
            else n_pass++;
            n_checks++;
            if (bus.rsp_valid !== exp_rsp_v)
                $display("FAIL rnd_rsp_valid cyc%0d: got %b want %b", cyc, bus.rsp_valid, exp_rsp_v);
            else n_pass++;
            for (int i = 0; i < N; i++) begin
                if (exp_rsp_v[i] && exp_q.size() > 0) begin
                    exp_d = exp_q.pop_front();
                    n_checks++;
                    if (bus.rsp_data[i] !== exp_d)
                        $display("FAIL rnd_rsp_data cyc%0d req%0d: got %h want %h", cyc, i,
                                 bus.rsp_data[i], exp_d);
                    else n_pass++;
                end
            end

            exp_rsp_v = exp_ready;
            for (int i = 0; i < N; i++)
                if (exp_ready[i]) exp_q.push_back(pwe[i] ? '0 : model_mem[pa[i][3:0]]);

            for (int i = 0; i < N; i++) begin
                if (pv[i]) begin
                    bound = pwe[i] ? N : (N + 1) / 2;
                    if (bus.req_ready[i] === 1'b1) begin
                        n_checks++;
                        if (waitc[i] + 1 > bound)
                            $display("FAIL rnd_starve cyc%0d req%0d: waited %0d want <= %0d",
                                     cyc, i, waitc[i] + 1, bound);
                        else n_pass++;
                        pv[i] = 1'b0;
                    end else begin
                        waitc[i]++;
                    end
                end
            end

            if (w_win >= 0) begin
                model_mem[pa[w_win][3:0]] = pd[w_win];
                m_wr = (w_win + 1) % N;
            end
            if (r1 >= 0)      m_rd = (r1 + 1) % N;
            else if (r0 >= 0) m_rd = (r0 + 1) % N;
            tick();
        end
        idle_inputs();
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (pv[i] && waitc[i] >= (pwe[i] ? N : (N + 1) / 2))
                $display("FAIL rnd_pending req%0d: waited %0d cycles ungranted", i, waitc[i]);
            else n_pass++;
        end
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_reset_mid();
        test_single_read();
        test_dual_read_write();
        test_round_robin();
        test_raw_same_cycle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end
endmodule
